// File: rtl/game_input_conditioner_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_input_conditioner_if : raw player inputs and the conditioned step bus
// Revision : 1.0
// ----------------------------------------------------------------------------
interface game_input_conditioner_if;
    logic       KEY_STEP_N;
    logic [5:0] SW_RAW;
    logic       STEP;
    logic [5:0] CMD;
    logic       CMD_CONFLICT;
    logic [7:0] STEP_COUNT;

    modport master (
        output KEY_STEP_N,
        output SW_RAW,
        input  STEP,
        input  CMD,
        input  CMD_CONFLICT,
        input  STEP_COUNT
    );

    modport slave (
        input  KEY_STEP_N,
        input  SW_RAW,
        output STEP,
        output CMD,
        output CMD_CONFLICT,
        output STEP_COUNT
    );
endinterface
`default_nettype wire

// File: rtl/game_input_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_input_conditioner : synchronizes the step key and switches, debounces
// the key and issues one STEP with a latched command per accepted press.
// Revision : 1.0
// ----------------------------------------------------------------------------
module game_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  wire logic               CLOCK,
    input  wire logic               RESET,
    game_input_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASE_WAIT = 2'd0,
        IDLE         = 2'd1,
        PRESS_WAIT   = 2'd2,
        HELD         = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_meta_q, key_meta_d;
    logic             key_sync_q, key_sync_d;
    logic [5:0]       sw_meta_q, sw_meta_d;
    logic [5:0]       sw_sync_q, sw_sync_d;
    logic             step_q, step_d;
    logic [5:0]       cmd_q, cmd_d;
    logic             conflict_q, conflict_d;
    logic [7:0]       step_count_q, step_count_d;
    logic             w_accept;
    logic             w_multi;

    // More than one bit set exactly when clearing the lowest set bit leaves something.
    assign w_multi = |(sw_sync_q & (sw_sync_q - 6'd1));

    always_comb begin
        key_meta_d   = bus.KEY_STEP_N;
        key_sync_d   = key_meta_q;
        sw_meta_d    = bus.SW_RAW;
        sw_sync_d    = sw_meta_q;
        state_d      = state_q;
        cnt_d        = '0;
        w_accept     = 1'b0;

        case (state_q)
            RELEASE_WAIT: begin
                if (key_sync_q) begin
                    if (cnt_q == c_cnt_last) state_d = IDLE;
                    else                     cnt_d   = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (!key_sync_q) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (key_sync_q) begin
                    state_d = IDLE;
                end else if (cnt_q == c_cnt_last) begin
                    state_d  = HELD;
                    w_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (key_sync_q) state_d = RELEASE_WAIT;
            end
            default: state_d = RELEASE_WAIT;
        endcase

        step_d       = w_accept;
        step_count_d = w_accept ? step_count_q + 8'd1 : step_count_q;
        cmd_d        = cmd_q;
        conflict_d   = conflict_q;
        if (w_accept) begin
            cmd_d      = w_multi ? 6'd0 : sw_sync_q;
            conflict_d = w_multi;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            key_meta_q   <= 1'b1;
            key_sync_q   <= 1'b1;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            state_q      <= RELEASE_WAIT;
            cnt_q        <= '0;
            step_q       <= 1'b0;
            cmd_q        <= '0;
            conflict_q   <= 1'b0;
            step_count_q <= '0;
        end else begin
            key_meta_q   <= key_meta_d;
            key_sync_q   <= key_sync_d;
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            cmd_q        <= cmd_d;
            conflict_q   <= conflict_d;
            step_count_q <= step_count_d;
        end
    end

    assign bus.STEP         = step_q;
    assign bus.CMD          = cmd_q;
    assign bus.CMD_CONFLICT = conflict_q;
    assign bus.STEP_COUNT   = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_game_input_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_game_input_conditioner : directed checks with DEBOUNCE_CYCLES = 4
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_game_input_conditioner;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_steps = 0;

    game_input_conditioner_if bus();

    game_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) if (bus.STEP === 1'b1) n_steps++;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cycles(3);
        RESET = 1'b0;
    endtask

    // Drives the key low; returns the 1-based index of the edge after which
    // STEP was seen (edge N is index 1), or -1 if it never came.
    task automatic press(output int lat);
        lat = -1;
        bus.KEY_STEP_N = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLOCK);
            #1;
            if (bus.STEP === 1'b1 && lat < 0) lat = i;
        end
    endtask

    task automatic release_key(input int n);
        bus.KEY_STEP_N = 1'b1;
        cycles(n);
    endtask

    int lat;
    int base;

    initial begin
        bus.KEY_STEP_N = 1'b1;
        bus.SW_RAW     = 6'b000000;
        cycles(3);
        check("rst_step",     int'(bus.STEP), 0);
        check("rst_cmd",      int'(bus.CMD), 0);
        check("rst_conflict", int'(bus.CMD_CONFLICT), 0);
        check("rst_count",    int'(bus.STEP_COUNT), 0);
        RESET = 1'b0;

        // 1: clean press
        release_key(10);
        bus.SW_RAW = 6'b001000;
        base = n_steps;
        press(lat);
        check("s1_latency",  lat, 7);
        check("s1_pulses",   n_steps - base, 1);
        check("s1_cmd",      int'(bus.CMD), 6'b001000);
        check("s1_conflict", int'(bus.CMD_CONFLICT), 0);
        check("s1_count",    int'(bus.STEP_COUNT), 1);

        // 2: bounce before a steady press
        do_reset();
        release_key(10);
        base = n_steps;
        bus.KEY_STEP_N = 1'b0;
        cycles(2);
        bus.KEY_STEP_N = 1'b1;
        cycles(1);
        press(lat);
        check("s2_latency", lat, 7);
        check("s2_pulses",  n_steps - base, 1);
        check("s2_count",   int'(bus.STEP_COUNT), 1);

        // 3: conflict then recovery
        do_reset();
        release_key(10);
        bus.SW_RAW = 6'b001010;
        press(lat);
        check("s3_latency",  lat, 7);
        check("s3_cmd",      int'(bus.CMD), 0);
        check("s3_conflict", int'(bus.CMD_CONFLICT), 1);
        release_key(10);
        bus.SW_RAW = 6'b000001;
        press(lat);
        check("s3_cmd2",      int'(bus.CMD), 6'b000001);
        check("s3_conflict2", int'(bus.CMD_CONFLICT), 0);
        check("s3_count",     int'(bus.STEP_COUNT), 2);

        // 4: long hold while switches move
        do_reset();
        release_key(10);
        bus.SW_RAW = 6'b000100;
        base = n_steps;
        press(lat);
        for (int i = 0; i < 100; i++) begin
            bus.SW_RAW = 6'(i * 7 + 3);
            cycles(1);
        end
        check("s4_pulses_hold", n_steps - base, 1);
        check("s4_cmd_held",    int'(bus.CMD), 6'b000100);
        release_key(10);
        press(lat);
        check("s4_latency2", lat, 7);
        check("s4_pulses",   n_steps - base, 2);
        check("s4_count",    int'(bus.STEP_COUNT), 2);

        // 5: reset while the press is being debounced, key held through release
        do_reset();
        release_key(10);
        base = n_steps;
        bus.KEY_STEP_N = 1'b0;
        cycles(4);
        RESET = 1'b1;
        cycles(2);
        RESET = 1'b0;
        cycles(20);
        check("s5_no_step", n_steps - base, 0);
        check("s5_count0",  int'(bus.STEP_COUNT), 0);
        release_key(10);
        press(lat);
        check("s5_latency", lat, 7);
        check("s5_count1",  int'(bus.STEP_COUNT), 1);

        // 6: counter wrap
        do_reset();
        release_key(10);
        base = n_steps;
        for (int i = 1; i <= 256; i++) begin
            bus.KEY_STEP_N = 1'b0;
            cycles(10);
            bus.KEY_STEP_N = 1'b1;
            cycles(10);
            if (i == 255) check("s6_count255", int'(bus.STEP_COUNT), 255);
        end
        check("s6_count_wrap", int'(bus.STEP_COUNT), 0);
        check("s6_pulses",     n_steps - base, 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
